// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that uses one full-adder cell and handles one bit per clock, LSB first.
// Optional build macro SERIAL_ADDER_SUB_EN adds the sub port, which selects subtract mode (a - b).
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request a new operation; it is accepted only in IDLE
//   a, b, c_in       operands and carry-in; all three are captured when start is accepted
//   sub              subtract select; it exists only when SERIAL_ADDER_SUB_EN is defined
//   busy             high while the operation is running
//   done             one-cycle pulse that marks sum/c_out as freshly valid
//   sum, c_out       result and final carry; they hold until the next operation completes
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-2:0]   res_q, res_d;   // low result bits; the last bit goes straight into sum
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_d;
   logic               c_out_d, busy_d, done_d;
   logic               b_bit, s_bit, c_nxt;
   logic [WIDTH-1:0]   res_full;
`ifdef SERIAL_ADDER_SUB_EN
   logic               sub_q, sub_d;
`endif

   // Full-adder cell on the current LSBs. In subtract mode the b bit is inverted here.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_bit = b_q[0] ^ sub_q;
`else
      b_bit = b_q[0];
`endif
      s_bit    = a_q[0] ^ b_bit ^ carry_q;
      c_nxt    = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
      res_full = {s_bit, res_q};
   end

   // Next-state logic and datapath control
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum;
      c_out_d = c_out;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               busy_d  = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
               sub_d   = sub;
               carry_d = sub ? 1'b1 : c_in;   // a + ~b + 1
`else
               carry_d = c_in;
`endif
            end
         end
         RUN: begin
            busy_d  = 1'b1;
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = res_full[WIDTH-1:1];
            carry_d = c_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = res_full;
               c_out_d = c_nxt;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         c_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum     <= sum_d;
         c_out   <= c_out_d;
         busy    <= busy_d;
         done    <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// A cycle-level behavioural model predicts busy/done/sum/c_out. The model uses a countdown and plain
// integer arithmetic. Directed cases pin literal results, and a random phase runs 200 operations.
module tb_serial_adder;

   localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         c_in = 1'b0;
   logic         sub = 1'b0;
   logic         busy, done, c_out;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: m_left counts the bit cycles still to go.
   // An operation ends in a one-cycle done, and a start is taken only when nothing is pending.
   int           m_left = 0;
   bit           m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic [W:0]   m_res = '0;
   int           m_ops = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0; m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_left != 0) begin
         m_left--;
         if (m_left == 0) begin
            {m_cout, m_sum} = m_res;
            m_done = 1; m_busy = 0;
         end
      end else if (start) begin
         if (SUB_EN && sub) m_res = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         else               m_res = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
         m_left = W; m_busy = 1; m_ops++;
      end
   end

   // Compare the DUT outputs against the model on every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("sum", 32'(sum), 32'(m_sum));
         check("c_out", 32'(c_out), 32'(m_cout));
      end
   end

   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci, input logic tsub);
      @(posedge clk); #1;
      a = ta; b = tb; c_in = tci; sub = tsub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done after the start edge. Optionally scramble the inputs and pulse start mid-run.
   task automatic wait_done(input bit scramble, output int lat, output int bcnt);
      lat  = 0;
      bcnt = busy ? 1 : 0;
      while (lat < 30) begin
         if (scramble) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            start = (lat == 2);
            if (lat == 2) a = 8'hFF;
         end
         @(posedge clk); lat++; #1;
         if (done) break;
         if (busy) bcnt++;
      end
      start = 1'b0;
   endtask

   task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tci, input logic tsub, input bit scramble,
                           input logic [W-1:0] esum, input logic ecout);
      int lat, bcnt;
      start_op(ta, tb, tci, tsub);
      wait_done(scramble, lat, bcnt);
      check({name, "_latency"}, 32'(lat), 32'(W));
      check({name, "_busy_cycles"}, 32'(bcnt), 32'(W));
      check({name, "_sum"}, 32'(sum), 32'(esum));
      check({name, "_c_out"}, 32'(c_out), 32'(ecout));
      @(posedge clk); #1;
      check({name, "_done_width"}, 32'(done), 32'd0);
   endtask

   initial begin
      int dcnt, base, cyc;
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_c_out", 32'(c_out), 32'd0);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      directed("zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      directed("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      directed("a5_5a_ci", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
      directed("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0);
      directed("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
      directed("sub0_add", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h31, 1'b0);
`endif
      directed("scramble", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0);

      // Reset in the middle of a run: the outputs clear at once and no done pulse follows.
      start_op(8'h80, 8'h80, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_c_out", 32'(c_out), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      dcnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      check("midrst_no_done", 32'(dcnt), 32'd0);
      directed("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0);

      // Random phase: start is asserted freely, and the model decides which starts are accepted.
      base = m_ops;
      cyc  = 0;
      while ((m_ops - base) < 200 && cyc < 20000) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 2) == 0);
         a     = 8'($urandom);
         b     = 8'($urandom);
         c_in  = 1'($urandom);
         sub   = 1'($urandom);
         cyc++;
      end
      start = 1'b0;
      check("random_ops", 32'(m_ops - base), 32'd200);
      repeat (W + 4) @(posedge clk);
      #1;
      check("final_idle_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 Port a, input, WIDTH: operand A; captured when start is accepted.
REQ-006 Port b, input, WIDTH: operand B; captured when start is accepted.
REQ-007 Port c_in, input, 1: carry-in; captured when start is accepted.
REQ-008 Port sub, input, 1: subtract mode select; present only when SERIAL_ADDER_SUB_EN is defined; captured when start is accepted.
REQ-009 Port busy, output, 1: high while the operation is in progress.
REQ-010 Port done, output, 1: one-cycle pulse, result valid.
REQ-011 Port sum, output, WIDTH: result, held until the next accepted start completes.
REQ-012 Port c_out, output, 1: final carry; held with sum.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 Transition IDLE->RUN: on a rising edge with start=1. This edge is E0; it loads the a/b shift registers, the carry flop (c_in) and the bit counter (0).
REQ-015 In RUN, each edge SHALL compute one bit, LSB first, using a single full-adder cell (s = a0^b0^c; c' = a0&b0 | c&(a0^b0)).
REQ-016 Bit handling SHALL shift s into the result register MSB and shift the operands right.
REQ-017 Transition RUN->DONE: at edge E_WIDTH, after bit WIDTH-1. At this edge sum takes the full result and c_out the final carry.
REQ-018 sum and c_out SHALL NOT change at any other time; partial results stay internal.
REQ-019 busy SHALL be 1 in the cycles after E0 through E_WIDTH, and 0 otherwise.
REQ-020 done SHALL be 1 for exactly the one cycle after E_WIDTH (state DONE); latency from the start edge to done is WIDTH cycles.
REQ-021 Transition DONE->IDLE: unconditional after one cycle.
REQ-022 A start asserted in DONE SHALL be ignored; start is accepted only in IDLE.
REQ-023 start asserted during RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-024 Changes on a, b, c_in or sub after the start edge SHALL NOT affect the result.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with c_out = bit WIDTH of a+b+c_in.
REQ-026 Back-to-back operations: minimum start-to-start spacing is WIDTH+2 cycles.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force: state IDLE, busy 0, done 0, sum 0, c_out 0, internal carry 0, internal counter 0.
REQ-028 Reset asserted mid-RUN SHALL abandon the operation; no done pulse follows.
REQ-029 After reset release, the first start SHALL be accepted normally.

Configuration
REQ-030 The SERIAL_ADDER_SUB_EN macro SHALL control subtract mode.
REQ-031 With SERIAL_ADDER_SUB_EN defined: port sub exists.
REQ-032 With SERIAL_ADDER_SUB_EN defined and sub=1 captured: each b bit is inverted at the cell, the carry flop initialises to 1 and c_in is ignored. Result: sum = a-b mod 2^WIDTH; c_out=1 means no borrow.
REQ-033 With SERIAL_ADDER_SUB_EN defined and sub=0 captured: behaviour is identical to the non-defined build.
REQ-034 Without SERIAL_ADDER_SUB_EN: no sub port and no inversion logic; the block adds only.

Verification (WIDTH=8)
REQ-035 Reset then start, a=0x00, b=0x00, c_in=0 -> busy 8 cycles, done pulse 8 cycles after the start edge, sum=0x00, c_out=0.
REQ-036 a=0xFF, b=0x01, c_in=0, then a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1 in both cases; done width exactly one cycle.
REQ-037 Start a=0x12, b=0x34; pulse start with a=0xFF at cycle 3 of RUN; change a/b every cycle -> single done, sum=0x46, c_out=0.
REQ-038 Start a=0x80, b=0x80; deassert rst_n at cycle 4 for 2 cycles -> busy, done, sum and c_out 0 immediately, no done pulse; a following start a=0x01, b=0x02 -> sum=0x03.
REQ-039 SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0; sub=1, a=0x07, b=0x05, c_in=1 -> sum=0x02, c_out=1.
REQ-040 The bench SHALL check random operands for 200 operations against a reference a+b+c_in in both builds.
